adder_sequencer: RTL and testbench

Byte-serial multi-byte add/subtract engine that shares one 8-bit `prefixadder` between two requesters. Requesters are served by round-robin arbitration. Operands are up to `8*NBYTES` bits and are processed LSB byte first, one byte per clock, with the carry held in a register between bytes. The block sits beside the processor ALU and serves wide arithmetic: address/offset math and multi-precision instructions from two independent clients.

---
 rtl/adder_seq_pkg.sv | 13 +
 rtl/adder_sequencer_prefixadder.sv | 45 ++++
 rtl/adder_sequencer.sv | 127 ++++++++++++
 tb/tb_adder_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract engine.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addseq_state_t;

  localparam int BYTE_W = 8;
  localparam int NREQ   = 2;

endpackage

// File: rtl/adder_sequencer_prefixadder.sv
// 8-bit Kogge-Stone prefix adder: the byte datapath of adder_sequencer.
module prefixadder
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W-1:0] g0, p0, g1, p1;
  logic [BYTE_W-1:0] g2, p2, g3, p3;
  logic [BYTE_W:0]   c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < BYTE_W; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < BYTE_W; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
    g3 = g2;
    p3 = p2;
    for (int i = 4; i < BYTE_W; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
      p3[i] = p2[i] & p2[i-4];
    end
  end

  // Group terms span bit 0..i, so cin folds in with one AND-OR.
  assign c    = {g3 | (p3 & {BYTE_W{cin}}), cin};
  assign s    = p0 ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule

// File: rtl/adder_sequencer.sv
// Round-robin shared byte-serial W-bit add/subtract engine.
// Define ADDSEQ_SUB_EN to honour req_sub; otherwise every op is an add.
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [8*NBYTES-1:0]   req_a0,
  input  logic [8*NBYTES-1:0]   req_b0,
  input  logic [8*NBYTES-1:0]   req_a1,
  input  logic [8*NBYTES-1:0]   req_b1,
  input  logic [1:0]            req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy
);

  localparam int W  = NBYTES * BYTE_W;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  addseq_state_t     state;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              carry, ptr, id_q;
  logic              cout_q, ovf_q;
  logic [NREQ-1:0]   grant;
  logic              sel, op_sub, accept;
  logic [BYTE_W-1:0] s_byte;
  logic              c_byte;

  // ptr holds the last requester served; a tie goes to the other one.
  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel       = grant[1];

`ifdef ADDSEQ_SUB_EN
  assign op_sub = req_sub[sel];
`else
  logic unused_sub;
  assign unused_sub = ^req_sub;
  assign op_sub     = 1'b0;
`endif

  prefixadder u_add (
    .a    (a_q[BYTE_W-1:0]),
    .b    (b_q[BYTE_W-1:0]),
    .cin  (carry),
    .s    (s_byte),
    .cout (c_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      ptr    <= 1'b1;
      id_q   <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= sel ? req_a1 : req_a0;
            b_q   <= (sel ? req_b1 : req_b0) ^ {W{op_sub}};
            carry <= op_sub;
            id_q  <= sel;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Result fills from the top; operands drain from the bottom.
          sum_q <= (sum_q >> BYTE_W) | (W'(s_byte) << (W - BYTE_W));
          a_q   <= a_q >> BYTE_W;
          b_q   <= b_q >> BYTE_W;
          carry <= c_byte;
          if (cnt == CW'(NBYTES - 1)) begin
            cout_q <= c_byte;
            ovf_q  <= (a_q[BYTE_W-1] == b_q[BYTE_W-1]) &
                      (s_byte[BYTE_W-1] != a_q[BYTE_W-1]);
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            ptr   <= id_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed self-checking bench for adder_sequencer (NBYTES=4).
module tb_adder_sequencer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sub;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_cout, rsp_ovf, busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] sum;
  logic        co, ov, id;
  int          lat;
  bit          to;

  always #5 clk = ~clk;

  adder_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  // Runs one transaction on requester r and returns the response fields.
  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output logic [31:0] o_sum,
                       output logic o_co, output logic o_ov, output logic o_id,
                       output int o_lat, output bit o_to);
    o_to  = 1'b0;
    o_lat = 0;
    @(posedge clk); #1;
    if (r == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_sub[r]   = s;
    req_valid[r] = 1'b1;
    rsp_ready    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[r]; i++) @(negedge clk);
    if (!req_ready[r]) o_to = 1'b1;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (!o_to) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        o_lat++;
        if (rsp_valid) break;
      end
      if (!rsp_valid) o_to = 1'b1;
    end
    o_sum = rsp_sum;
    o_co  = rsp_cout;
    o_ov  = rsp_ovf;
    o_id  = rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b00;
    #12;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL rst_sum got=%h exp=0", rsp_sum); end
    checks++; if ({rsp_id, rsp_cout, rsp_ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {rsp_id, rsp_cout, rsp_ovf}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_tie got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, sum, co, ov, id, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_timeout got=%b exp=0", to); end
    checks++; if (lat != 5) begin errors++; $display("FAIL add_latency got=%0d exp=5", lat); end
    checks++; if (sum !== 32'h0000_0100) begin errors++; $display("FAIL add_sum got=%h exp=00000100", sum); end
    checks++; if ({co, ov, id} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b exp=000", {co, ov, id}); end
    do_op(1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, sum, co, ov, id, lat, to);
    checks++; if (sum !== 32'h2143_6587) begin errors++; $display("FAIL add1_sum got=%h exp=21436587", sum); end
    checks++; if (id !== 1'b1) begin errors++; $display("FAIL add1_id got=%b exp=1", id); end
  endtask

  task automatic test_carry_ovf;
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, sum, co, ov, id, lat, to);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL carry_sum got=%h exp=00000000", sum); end
    checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL carry_flags got=%b exp=10", {co, ov}); end
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, sum, co, ov, id, lat, to);
    checks++; if (sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum got=%h exp=80000000", sum); end
    checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL ovf_flags got=%b exp=01", {co, ov}); end
  endtask

  task automatic test_sub;
    logic [31:0] e1, e2;
    logic [1:0]  f1, f2;
`ifdef ADDSEQ_SUB_EN
    e1 = 32'hFFFF_FFFE; f1 = 2'b00;
    e2 = 32'h7FFF_FFFF; f2 = 2'b11;
`else
    e1 = 32'h0000_000C; f1 = 2'b00;
    e2 = 32'h8000_0001; f2 = 2'b00;
`endif
    do_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, sum, co, ov, id, lat, to);
    checks++; if (sum !== e1) begin errors++; $display("FAIL sub1_sum got=%h exp=%h", sum, e1); end
    checks++; if ({co, ov} !== f1) begin errors++; $display("FAIL sub1_flags got=%b exp=%b", {co, ov}, f1); end
    do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, sum, co, ov, id, lat, to);
    checks++; if (sum !== e2) begin errors++; $display("FAIL sub2_sum got=%h exp=%h", sum, e2); end
    checks++; if ({co, ov} !== f2) begin errors++; $display("FAIL sub2_flags got=%b exp=%b", {co, ov}, f2); end
    req_sub = 2'b00;
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_sum;
    rst_n = 1'b0;
    req_a0 = 32'd10;      req_b0 = 32'd20;
    req_a1 = 32'h100;     req_b1 = 32'h200;
    req_sub = 2'b00;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      exp_sum = (k % 2 == 1) ? 32'h300 : 32'd30;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_id !== 1'(k % 2)) begin errors++; $display("FAIL rr_id[%0d] got=%b exp=%0d", k, rsp_id, k % 2); end
      checks++; if (rsp_sum !== exp_sum) begin errors++; $display("FAIL rr_sum[%0d] got=%h exp=%h", k, rsp_sum, exp_sum); end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_a0 = 32'h0102_0304; req_b0 = 32'h1020_3040;
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[0]; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_a1 = 32'h0000_FFFF; req_b1 = 32'h0000_0001;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      checks++; if (rsp_sum !== 32'h1122_3344) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=11223344", i, rsp_sum); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got=%b exp=1", i, busy); end
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_fourth got=%b exp=1", rsp_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_ready got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    checks++; if ({rsp_valid, rsp_id} !== 2'b11) begin errors++; $display("FAIL bp_next_rsp got=%b exp=11", {rsp_valid, rsp_id}); end
    checks++; if (rsp_sum !== 32'h0001_0000) begin errors++; $display("FAIL bp_next_sum got=%h exp=00010000", rsp_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_run;
    int seen;
    seen = 0;
    rsp_ready = 1'b1;
    req_a0 = 32'hAAAA_AAAA; req_b0 = 32'h5555_5555;
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready[0]; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rrun_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rrun_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rrun_no_rsp got=%0d exp=0", seen); end
    do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, sum, co, ov, id, lat, to);
    checks++; if (sum !== 32'h2345_6789) begin errors++; $display("FAIL rrun_sum got=%h exp=23456789", sum); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rrun_timeout got=%b exp=0", to); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_sub = 2'b00;
    req_a0 = '0; req_b0 = '0;
    req_a1 = '0; req_b1 = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
